// File: rtl/alu_issue_ctrl.sv
// Issue controller between the multi-cycle datapath and the 4-bit-op ALU.
// Optional build macro ALU_ZF_CHECK_EN adds the sticky zf_mismatch output.
module alu_issue_ctrl #(
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // valid holds its payload until that edge; ready never depends on valid.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_aluop,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [3:0]        op,
  output logic [DATA_W-1:0] din1_alu,
  output logic [DATA_W-1:0] din2_alu,
  input  logic [DATA_W-1:0] result_alu,
  input  logic              ZF,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zf,
  output logic              rsp_err,
`ifdef ALU_ZF_CHECK_EN
  output logic              zf_mismatch,
`endif
  output logic [1:0]        state_dbg
);

  // Out-of-range settle times fall back to the shortest legal value.
  localparam int SC = ((SETTLE_CYC < 1) || (SETTLE_CYC > 15)) ? 1 : SETTLE_CYC;
  localparam logic [3:0] SC_LOAD = 4'(SC - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          op_d;
  logic [DATA_W-1:0]   din1_d, din2_d;
  logic [DATA_W-1:0]   rsp_result_d;
  logic                rsp_zf_d, rsp_err_d;
  logic                dec_legal;
  logic [3:0]          dec_op;
`ifdef ALU_ZF_CHECK_EN
  logic                zf_mismatch_d;
`endif

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    case (req_aluop)
      2'b00: begin dec_legal = 1'b1; dec_op = OP_ADD; end
      2'b01: begin dec_legal = 1'b1; dec_op = OP_SUB; end
      2'b10: begin
        case (req_funct)
          6'b100000: begin dec_legal = 1'b1; dec_op = OP_ADD; end
          6'b100010: begin dec_legal = 1'b1; dec_op = OP_SUB; end
          6'b100100: begin dec_legal = 1'b1; dec_op = OP_AND; end
          6'b100101: begin dec_legal = 1'b1; dec_op = OP_OR;  end
          6'b101010: begin dec_legal = 1'b1; dec_op = OP_SLT; end
          6'b100111: begin dec_legal = 1'b1; dec_op = OP_NOR; end
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op;
    din1_d       = din1_alu;
    din2_d       = din2_alu;
    rsp_result_d = rsp_result;
    rsp_zf_d     = rsp_zf;
    rsp_err_d    = rsp_err;
`ifdef ALU_ZF_CHECK_EN
    zf_mismatch_d = zf_mismatch;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_legal) begin
            op_d    = dec_op;
            din1_d  = req_a;
            din2_d  = req_b;
            cnt_d   = SC_LOAD;
            state_d = ISSUE;
          end else begin
            // Illegal requests leave the ALU inputs alone and answer at once.
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zf_d     = 1'b0;
            state_d      = RESP;
          end
        end
      end
      ISSUE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d = result_alu;
          rsp_zf_d     = ZF;
          rsp_err_d    = 1'b0;
          state_d      = RESP;
`ifdef ALU_ZF_CHECK_EN
          if (ZF != (result_alu == '0)) zf_mismatch_d = 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op         <= OP_ADD;
      din1_alu   <= '0;
      din2_alu   <= '0;
      rsp_result <= '0;
      rsp_zf     <= 1'b0;
      rsp_err    <= 1'b0;
`ifdef ALU_ZF_CHECK_EN
      zf_mismatch <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op         <= op_d;
      din1_alu   <= din1_d;
      din2_alu   <= din2_d;
      rsp_result <= rsp_result_d;
      rsp_zf     <= rsp_zf_d;
      rsp_err    <= rsp_err_d;
`ifdef ALU_ZF_CHECK_EN
      zf_mismatch <= zf_mismatch_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign state_dbg = state_q;

  a_issue_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == ISSUE) |=> (state_q != ISSUE) || $stable({op, din1_alu, din2_alu}));

  a_resp_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == RESP && !rsp_ready) |=> (state_q == RESP) && $stable({rsp_result, rsp_zf, rsp_err}));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (settle 1 and settle 4) with a behavioural ALU each.
// Build with ALU_ZF_CHECK_EN defined to also exercise zf_mismatch.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   sel = 0;
  logic req_valid = 1'b0;
  logic rsp_ready = 1'b0;
  logic [1:0]  req_aluop = 2'b00;
  logic [5:0]  req_funct = 6'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic force_zf = 1'b0;

  logic        v_i[2], r_i[2], req_ready_o[2], rsp_valid_o[2], rsp_zf_o[2], rsp_err_o[2], zf_i[2];
  logic [3:0]  op_o[2];
  logic [1:0]  st_o[2];
  logic [31:0] d1_o[2], d2_o[2], res_i[2], rsp_res_o[2];
`ifdef ALU_ZF_CHECK_EN
  logic        zfm_o[2];
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [3:0]  last_op[2];
  logic [31:0] last_a[2], last_b[2];
  logic [31:0] got_result;

  function automatic logic [31:0] alu_env(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      v_i[i]   = req_valid && (sel == i);
      r_i[i]   = (sel == i) ? rsp_ready : 1'b1;
      res_i[i] = alu_env(op_o[i], d1_o[i], d2_o[i]);
      zf_i[i]  = force_zf ? 1'b1 : (res_i[i] == 32'd0);
    end
  end

  alu_issue_ctrl #(.DATA_W(32), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v_i[0]), .req_ready(req_ready_o[0]),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .op(op_o[0]), .din1_alu(d1_o[0]), .din2_alu(d2_o[0]), .result_alu(res_i[0]), .ZF(zf_i[0]),
    .rsp_valid(rsp_valid_o[0]), .rsp_ready(r_i[0]), .rsp_result(rsp_res_o[0]),
    .rsp_zf(rsp_zf_o[0]), .rsp_err(rsp_err_o[0]),
`ifdef ALU_ZF_CHECK_EN
    .zf_mismatch(zfm_o[0]),
`endif
    .state_dbg(st_o[0]));

  alu_issue_ctrl #(.DATA_W(32), .SETTLE_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(v_i[1]), .req_ready(req_ready_o[1]),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .op(op_o[1]), .din1_alu(d1_o[1]), .din2_alu(d2_o[1]), .result_alu(res_i[1]), .ZF(zf_i[1]),
    .rsp_valid(rsp_valid_o[1]), .rsp_ready(r_i[1]), .rsp_result(rsp_res_o[1]),
    .rsp_zf(rsp_zf_o[1]), .rsp_err(rsp_err_o[1]),
`ifdef ALU_ZF_CHECK_EN
    .zf_mismatch(zfm_o[1]),
`endif
    .state_dbg(st_o[1]));

  // Reference: what the request should compute, straight from the operation table.
  function automatic void ref_model(input logic [1:0] aluop, input logic [5:0] funct,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic legal, output logic [3:0] eop, output logic [31:0] res);
    legal = 1'b1; eop = 4'b0010; res = 32'd0;
    if (aluop == 2'b00) begin eop = 4'b0010; res = a + b; end
    else if (aluop == 2'b01) begin eop = 4'b0110; res = a - b; end
    else if (aluop == 2'b10) begin
      case (funct)
        6'b100000: begin eop = 4'b0010; res = a + b; end
        6'b100010: begin eop = 4'b0110; res = a - b; end
        6'b100100: begin eop = 4'b0000; res = a & b; end
        6'b100101: begin eop = 4'b0001; res = a | b; end
        6'b101010: begin eop = 4'b0111; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        6'b100111: begin eop = 4'b1100; res = ~(a | b); end
        default:   legal = 1'b0;
      endcase
    end else legal = 1'b0;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      last_op[i] = 4'b0010; last_a[i] = 32'd0; last_b[i] = 32'd0;
    end
  endtask

  task automatic do_req(input logic [1:0] aluop, input logic [5:0] funct,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic legal, ezf;
    logic [3:0] eop;
    logic [31:0] eres, xa, xb;
    int lat, exp_lat;
    ref_model(aluop, funct, a, b, legal, eop, eres);
    ezf = legal ? (force_zf ? 1'b1 : (eres == 32'd0)) : 1'b0;
    if (!legal) eres = 32'd0;
    exp_lat = legal ? ((sel == 1) ? 5 : 2) : 1;
    xa = legal ? a : last_a[sel];
    xb = legal ? b : last_b[sel];
    if (legal) eop = eop; else eop = last_op[sel];
    n_checks++;
    if (req_ready_o[sel] !== 1'b1) begin n_fail++; $display("FAIL req_ready_idle got %b exp 1", req_ready_o[sel]); end
    req_aluop = aluop; req_funct = funct; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = (hold > 0);
    req_aluop = 2'($urandom_range(0, 3)); req_funct = 6'($urandom); req_a = $urandom; req_b = $urandom;
    lat = 1;
    while (rsp_valid_o[sel] !== 1'b1 && lat < 40) begin
      n_checks++;
      if (op_o[sel] !== eop || d1_o[sel] !== xa || d2_o[sel] !== xb || req_ready_o[sel] !== 1'b0) begin
        n_fail++;
        $display("FAIL issue_hold got op=%b a=%h b=%h rdy=%b exp op=%b a=%h b=%h rdy=0",
                 op_o[sel], d1_o[sel], d2_o[sel], req_ready_o[sel], eop, xa, xb);
      end
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== exp_lat) begin n_fail++; $display("FAIL latency got %0d exp %0d", lat, exp_lat); end
    got_result = rsp_res_o[sel];
    for (int h = 0; h <= hold; h++) begin
      n_checks++;
      if (rsp_valid_o[sel] !== 1'b1 || rsp_res_o[sel] !== eres || rsp_zf_o[sel] !== ezf ||
          rsp_err_o[sel] !== !legal || req_ready_o[sel] !== 1'b0) begin
        n_fail++;
        $display("FAIL response got v=%b res=%h zf=%b err=%b rdy=%b exp v=1 res=%h zf=%b err=%b rdy=0",
                 rsp_valid_o[sel], rsp_res_o[sel], rsp_zf_o[sel], rsp_err_o[sel], req_ready_o[sel], eres, ezf, !legal);
      end
      n_checks++;
      if (op_o[sel] !== eop || d1_o[sel] !== xa || d2_o[sel] !== xb) begin
        n_fail++;
        $display("FAIL alu_inputs got op=%b a=%h b=%h exp op=%b a=%h b=%h", op_o[sel], d1_o[sel], d2_o[sel], eop, xa, xb);
      end
      if (h < hold) begin @(posedge clk); #1; end
    end
    // Response handshake with a competing request that must not be taken.
    rsp_ready = 1'b1; req_valid = 1'b1; req_aluop = 2'b00;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    n_checks++;
    if (rsp_valid_o[sel] !== 1'b0 || req_ready_o[sel] !== 1'b1) begin
      n_fail++; $display("FAIL after_handshake got v=%b rdy=%b exp v=0 rdy=1", rsp_valid_o[sel], req_ready_o[sel]);
    end
    if (legal) begin last_op[sel] = eop; last_a[sel] = a; last_b[sel] = b; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (req_ready_o[i] !== 1'b1 || rsp_valid_o[i] !== 1'b0 || op_o[i] !== 4'b0010 || d1_o[i] !== 32'd0 ||
          d2_o[i] !== 32'd0 || rsp_res_o[i] !== 32'd0 || rsp_zf_o[i] !== 1'b0 || rsp_err_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state inst=%0d got rdy=%b v=%b op=%b a=%h b=%h res=%h zf=%b err=%b exp 1 0 0010 0 0 0 0 0",
                 i, req_ready_o[i], rsp_valid_o[i], op_o[i], d1_o[i], d2_o[i], rsp_res_o[i], rsp_zf_o[i], rsp_err_o[i]);
      end
`ifdef ALU_ZF_CHECK_EN
      n_checks++;
      if (zfm_o[i] !== 1'b0) begin n_fail++; $display("FAIL reset_zf_mismatch got %b exp 0", zfm_o[i]); end
`endif
    end
    rst = 1'b0;
    reset_model();
    @(negedge clk); #1;
  endtask

  task automatic test_add_sub();
    sel = 0;
    do_req(2'b00, 6'd0, 32'd5, 32'd7, 0);
    n_checks++;
    if (got_result !== 32'd12) begin n_fail++; $display("FAIL add_5_7 got %h exp 0000000c", got_result); end
    do_req(2'b01, 6'd0, 32'd9, 32'd9, 0);
    n_checks++;
    if (got_result !== 32'd0) begin n_fail++; $display("FAIL sub_9_9 got %h exp 00000000", got_result); end
  endtask

  task automatic test_rtype_sweep();
    logic [5:0]  fn[4];
    logic [31:0] ex[4];
    fn[0] = 6'b100100; ex[0] = 32'h000F000F;
    fn[1] = 6'b100101; ex[1] = 32'h0FFF0FFF;
    fn[2] = 6'b101010; ex[2] = 32'h00000000;
    fn[3] = 6'b100111; ex[3] = 32'hF000F000;
    sel = 0;
    for (int k = 0; k < 4; k++) begin
      do_req(2'b10, fn[k], 32'h0F0F0F0F, 32'h00FF00FF, 0);
      n_checks++;
      if (got_result !== ex[k]) begin n_fail++; $display("FAIL rtype_%0d got %h exp %h", k, got_result, ex[k]); end
    end
    do_req(2'b10, 6'b100000, 32'hFFFFFFFF, 32'd1, 0);
    do_req(2'b10, 6'b100010, 32'd3, 32'd10, 0);
    do_req(2'b10, 6'b101010, 32'hFFFFFFFE, 32'd1, 0);
  endtask

  task automatic test_illegal();
    sel = 0;
    do_req(2'b10, 6'b000000, 32'h1111, 32'h2222, 0);
    do_req(2'b11, 6'b100000, 32'h3333, 32'h4444, 1);
  endtask

  task automatic test_backpressure();
    sel = 1;
    do_req(2'b01, 6'd0, 32'h1234, 32'h0011, 6);
    do_req(2'b10, 6'b100100, 32'hFFFF0000, 32'h0F0F0F0F, 2);
    do_req(2'b10, 6'b111111, 32'h5, 32'h6, 3);
  endtask

  task automatic test_random();
    logic [5:0] ftab[8];
    ftab[0] = 6'b100000; ftab[1] = 6'b100010; ftab[2] = 6'b100100; ftab[3] = 6'b100101;
    ftab[4] = 6'b101010; ftab[5] = 6'b100111; ftab[6] = 6'b000000; ftab[7] = 6'b111010;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      sel = n % 2;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_req(2'($urandom_range(0, 3)), ftab[$urandom_range(0, 7)], a, b, $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_midop();
    sel = 1;
    req_aluop = 2'b00; req_funct = 6'd0; req_a = 32'd40; req_b = 32'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (req_ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL midop_in_issue got rdy=%b exp 0", req_ready_o[1]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    n_checks++;
    if (req_ready_o[1] !== 1'b1 || rsp_valid_o[1] !== 1'b0 || op_o[1] !== 4'b0010 || d1_o[1] !== 32'd0) begin
      n_fail++;
      $display("FAIL midop_reset got rdy=%b v=%b op=%b a=%h exp 1 0 0010 0", req_ready_o[1], rsp_valid_o[1], op_o[1], d1_o[1]);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid_o[1] !== 1'b0) begin n_fail++; $display("FAIL midop_no_rsp cycle %0d got %b exp 0", c, rsp_valid_o[1]); end
    end
  endtask

`ifdef ALU_ZF_CHECK_EN
  task automatic test_zf_check();
    sel = 0;
    n_checks++;
    if (zfm_o[0] !== 1'b0) begin n_fail++; $display("FAIL zfm_initial got %b exp 0", zfm_o[0]); end
    force_zf = 1'b1;
    do_req(2'b00, 6'd0, 32'd1, 32'd2, 0);
    force_zf = 1'b0;
    n_checks++;
    if (zfm_o[0] !== 1'b1) begin n_fail++; $display("FAIL zfm_set got %b exp 1", zfm_o[0]); end
    do_req(2'b00, 6'd0, 32'd4, 32'd4, 1);
    n_checks++;
    if (zfm_o[0] !== 1'b1) begin n_fail++; $display("FAIL zfm_sticky got %b exp 1", zfm_o[0]); end
    n_checks++;
    if (zfm_o[1] !== 1'b0) begin n_fail++; $display("FAIL zfm_other_inst got %b exp 0", zfm_o[1]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    n_checks++;
    if (zfm_o[0] !== 1'b0) begin n_fail++; $display("FAIL zfm_cleared got %b exp 0", zfm_o[0]); end
  endtask
`endif

  initial begin
    reset_model();
    test_reset();
    test_add_sub();
    test_rtype_sweep();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_midop();
`ifdef ALU_ZF_CHECK_EN
    test_zf_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
